// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the Avalon load/store unit: access sizes, FSM states and
// the data-width to byte-lane helper.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lane.sv
// Byte-lane steering: byteenable pattern, store-data shift into lanes and
// load-data extract with sign/zero extension.
module mips_cpu_bus_lane
  import mips_cpu_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NL = lane_count(DATA_W),
  localparam int LB = $clog2(NL)
) (
  input  logic [LB-1:0]     i_offset,
  input  size_e             i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [NL-1:0]     o_byteenable,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [NL-1:0]     w_lane_mask;
  logic [DATA_W-1:0] w_data_mask;
  logic [LB+2:0]     w_shamt;
  logic [DATA_W-1:0] w_rshift;
  logic              w_sign;

  // Size-dependent lane and bit masks, right-justified before shifting.
  always_comb begin
    w_lane_mask = '0;
    w_data_mask = '0;
    case (i_size)
      SZ_BYTE: begin
        w_lane_mask = NL'(1);
        w_data_mask = DATA_W'(8'hFF);
      end
      SZ_HALF: begin
        w_lane_mask = NL'(3);
        w_data_mask = DATA_W'(16'hFFFF);
      end
      SZ_WORD: begin
        w_lane_mask = NL'(4'hF);
        w_data_mask = DATA_W'(32'hFFFF_FFFF);
      end
      SZ_DWORD: begin
        w_lane_mask = {NL{1'b1}};
        w_data_mask = {DATA_W{1'b1}};
      end
      default: begin
        w_lane_mask = '0;
        w_data_mask = '0;
      end
    endcase
  end

  assign w_shamt      = {i_offset, 3'b000};
  assign o_byteenable = w_lane_mask << i_offset;
  assign o_wdata      = (i_wdata & w_data_mask) << w_shamt;
  assign w_rshift     = i_rdata >> w_shamt;

  // Fill with the sign bit first, then overlay the addressed bytes.
  always_comb begin
    w_sign  = 1'b0;
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: begin
        w_sign       = i_signed & w_rshift[7];
        o_rdata      = {DATA_W{w_sign}};
        o_rdata[7:0] = w_rshift[7:0];
      end
      SZ_HALF: begin
        w_sign        = i_signed & w_rshift[15];
        o_rdata       = {DATA_W{w_sign}};
        o_rdata[15:0] = w_rshift[15:0];
      end
      SZ_WORD: begin
        w_sign        = i_signed & w_rshift[31];
        o_rdata       = {DATA_W{w_sign}};
        o_rdata[31:0] = w_rshift[31:0];
      end
      SZ_DWORD: begin
        w_sign  = 1'b0;
        o_rdata = w_rshift;
      end
      default: begin
        w_sign  = 1'b0;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// Load/store unit bridging a single-request CPU port to an Avalon-MM master,
// with alignment checking, lane steering and a waitrequest timeout.
module mips_cpu_bus_lsu
  import mips_cpu_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  memread,
  output logic                  memwrite,
  input  logic                  waitrequest,
  output logic [DATA_W-1:0]     memwritedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     memreaddata
);

  localparam int NL = lane_count(DATA_W);
  localparam int LB = $clog2(NL);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  size_e             r_size;
  logic              r_signed;
  logic              r_write;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CW-1:0]     r_wait_cnt;

  logic              w_illegal;
  logic              w_timeout;
  logic [NL-1:0]     w_be;
  logic [DATA_W-1:0] w_st_data;
  logic [DATA_W-1:0] w_ld_data;

  mips_cpu_bus_lane #(.DATA_W(DATA_W)) u_lane (
    .i_offset     (r_addr[LB-1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_wdata      (r_wdata),
    .i_rdata      (memreaddata),
    .o_byteenable (w_be),
    .o_wdata      (w_st_data),
    .o_rdata      (w_ld_data)
  );

  // Dword on a 32-bit bus has no lane pattern, so it is rejected like a misalignment.
  always_comb begin
    w_illegal = 1'b1;
    case (size_e'(req_size))
      SZ_BYTE:  w_illegal = 1'b0;
      SZ_HALF:  w_illegal = req_addr[0];
      SZ_WORD:  w_illegal = |req_addr[1:0];
      SZ_DWORD: w_illegal = (|req_addr[2:0]) | (DATA_W == 32);
      default:  w_illegal = 1'b1;
    endcase
  end

  assign w_timeout = (r_state == BUS) & waitrequest &
                     (r_wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_illegal ? RESP : BUS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUS: begin
        if (!waitrequest || w_timeout) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = BUS;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture, wait counting and response data; reset also abandons any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_size     <= size_e'(req_size);
            r_signed   <= req_signed;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            r_err      <= w_illegal;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            r_rdata    <= r_write ? '0 : w_ld_data;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        RESP: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = (r_state == RESP);
  assign resp_err     = (r_state == RESP) & r_err;
  assign resp_rdata   = r_rdata;
  assign memread      = (r_state == BUS) & ~r_write;
  assign memwrite     = (r_state == BUS) & r_write;
  assign mem_address  = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};
  assign byteenable   = (r_state == BUS) ? w_be : '0;
  assign memwritedata = ((r_state == BUS) && r_write) ? w_st_data : '0;

endmodule

// File: doc/mips_cpu_bus_lsu.md
MIPS_CPU_BUS_LSU -- requirements
Module: mips_cpu_bus_lsu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the Avalon data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum number of waitrequest-high cycles before abort.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be as follows (clock and reset first):
clk  in  1  clock.
reset  in  1  synchronous active-high reset.
req_valid  in  1  access request.
req_ready  out  1  request accepted when high with req_valid.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only if DATA_W=64).
req_signed  in  1  sign-extend load result.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  DATA_W  extended load data; 0 for stores.
resp_err  out  1  misaligned, illegal size, or timeout; valid with resp_valid.
mem_address  out  ADDR_W  lane-aligned byte address.
memread  out  1  Avalon read strobe.
memwrite  out  1  Avalon write strobe.
waitrequest  in  1  Avalon stall.
memwritedata  out  DATA_W  lane-shifted store data.
byteenable  out  DATA_W/8  active lanes.
memreaddata  in  DATA_W  read data, valid in the cycle waitrequest is low.

Function
REQ-006 The FSM SHALL have states IDLE, BUS and RESP; req_ready SHALL equal (state==IDLE).
REQ-007 In IDLE with req_valid, the block SHALL register the request; legal requests go to BUS, illegal requests go straight to RESP with resp_err=1 and no bus strobe.
REQ-008 A request SHALL be illegal if req_addr is not aligned to 2^req_size bytes, or if req_size=11 with DATA_W=32.
REQ-009 In BUS, exactly one of memread or memwrite SHALL be high, and all of mem_address, byteenable and memwritedata SHALL be held constant until the cycle waitrequest is low.
REQ-010 mem_address SHALL equal req_addr with its low log2(DATA_W/8) bits cleared.
REQ-011 byteenable SHALL have 2^req_size contiguous ones starting at lane req_addr[log2(DATA_W/8)-1:0].
REQ-012 memwritedata SHALL be req_wdata shifted left by 8*lane offset; unused lanes SHALL be 0.
REQ-013 On the BUS cycle with waitrequest low, the block SHALL capture memreaddata, go to RESP, and deassert strobes in the next cycle.
REQ-014 resp_rdata SHALL be the addressed bytes shifted to bit 0, then sign-extended if req_signed, else zero-extended; dword ignores req_signed.
REQ-015 Minimum latency SHALL be: acceptance at cycle N, strobe at N+1, and with no wait, resp_valid at N+2; throughput SHALL be one access per 3 cycles.
REQ-016 A wait counter SHALL count BUS cycles with waitrequest high; on reaching TIMEOUT, the block SHALL drop the strobes, go to RESP with resp_err=1, and set resp_rdata=0.
REQ-017 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-018 A request presented in BUS or RESP SHALL be ignored (req_ready=0), and the requester SHALL hold it.

Reset
REQ-019 Reset SHALL force state IDLE, zero the wait counter, and drive all outputs to 0 except req_ready, which becomes 1 in the cycle after reset.
REQ-020 Reset asserted during BUS SHALL abandon the access: strobes low on the next edge, and no resp_valid.

Structure
REQ-021 Package mips_cpu_bus_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), the state enum, and the lane-count function.
REQ-022 Byte-lane alignment SHALL be done in one combinational sub-module, mips_cpu_bus_lane, which performs byteenable generation, store shift and load extract/extend.

Verification
REQ-023 Load byte, signed, addr 0x1003, memreaddata 0x80FF_FF00, DATA_W=32, no wait -> byteenable 1000, mem_address 0x1000, resp_rdata 0xFFFF_FF80 at N+2.
REQ-024 Store half 0xBEEF to addr 0x2002, waitrequest high 3 cycles -> memwrite held 4 cycles, byteenable 1100, memwritedata 0xBEEF_0000, resp_err 0.
REQ-025 Load word at addr 0x3001 -> no strobe, resp_valid at N+1 with resp_err 1.
REQ-026 waitrequest stuck high, TIMEOUT=8 -> strobe drops after 8 cycles, resp_err 1, block returns to IDLE.
REQ-027 reset pulsed on the second BUS cycle -> memread 0 on the next edge, no resp_valid, req_ready 1 afterwards.
REQ-028 DATA_W=64, dword load at 0x8 -> byteenable 0xFF, resp_rdata = memreaddata.
